// File: rtl/stab_pkg.sv
// Shared types and sizing helpers for the stabilization motion-estimation path.
package stab_pkg;

  typedef enum logic [1:0] {ACCUM, LOAD, DIV, DONE} motion_state_t;

  localparam int unsigned DEFAULT_MAX_DISP = 31;

  // Accumulator width: widest displacement plus room for CNT_WIDTH worth of additions.
  function automatic int unsigned sum_width(input int unsigned xw, input int unsigned yw,
                                            input int unsigned cw);
    return ((xw > yw) ? xw : yw) + 1 + cw;
  endfunction

endpackage

// File: rtl/seq_divider_u.sv
// Unsigned restoring divider: one quotient bit per cycle after start, W cycles total.
module seq_divider_u #(
  parameter int unsigned W  = 21,
  parameter int unsigned DW = 10,
  parameter int unsigned QW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic          done
);

  localparam int unsigned IW = $clog2(W + 1);

  logic [W-1:0]  q;
  logic [DW-1:0] rem;
  logic [DW-1:0] div_r;
  logic [IW-1:0] iter;
  logic          active;
  logic [DW:0]   trial;
  logic [DW:0]   diff;

  assign trial    = {rem, q[W-1]};
  assign diff     = trial - {1'b0, div_r};
  assign done     = active && (iter == IW'(1));
  assign quotient = q[QW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      rem    <= '0;
      div_r  <= '0;
      iter   <= '0;
      active <= 1'b0;
    end else if (start) begin
      q      <= dividend;
      rem    <= '0;
      div_r  <= divisor;
      iter   <= IW'(W);
      active <= 1'b1;
    end else if (active) begin
      // Remainder stays below the divisor, so the trial value always fits DW+1 bits.
      if (trial >= {1'b0, div_r}) begin
        rem <= diff[DW-1:0];
        q   <= {q[W-2:0], 1'b1};
      end else begin
        rem <= trial[DW-1:0];
        q   <= {q[W-2:0], 1'b0};
      end
      iter <= iter - IW'(1);
      if (iter == IW'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/pair_motion_estimator.sv
// Accumulates matched-pair displacements per frame, rejects outliers, and divides
// the sums by the accepted count to produce the mean frame motion vector.
module pair_motion_estimator
  import stab_pkg::*;
#(
  parameter int unsigned X_WIDTH   = 10,
  parameter int unsigned Y_WIDTH   = 10,
  parameter int unsigned CNT_WIDTH = 10,
  parameter int unsigned MAX_DISP  = DEFAULT_MAX_DISP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pair_valid,
  input  logic                 pair_done,
  input  logic [X_WIDTH-1:0]   current_feature_X,
  input  logic [Y_WIDTH-1:0]   current_feature_Y,
  input  logic [X_WIDTH-1:0]   prev_feature_X,
  input  logic [Y_WIDTH-1:0]   prev_feature_Y,
  output logic                 busy,
  output logic                 motion_valid,
  output logic signed [X_WIDTH:0] motion_dx,
  output logic signed [Y_WIDTH:0] motion_dy,
  output logic                 motion_empty,
  output logic [CNT_WIDTH-1:0] pair_count,
  output logic [CNT_WIDTH-1:0] reject_count
);

  localparam int unsigned SW    = sum_width(X_WIDTH, Y_WIDTH, CNT_WIDTH);
  localparam int unsigned EXT_X = SW - X_WIDTH - 1;
  localparam int unsigned EXT_Y = SW - Y_WIDTH - 1;
  localparam logic [X_WIDTH:0]   MAX_DX  = (X_WIDTH + 1)'(MAX_DISP);
  localparam logic [Y_WIDTH:0]   MAX_DY  = (Y_WIDTH + 1)'(MAX_DISP);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  motion_state_t state, next;

  logic signed [X_WIDTH:0] dx;
  logic signed [Y_WIDTH:0] dy;
  logic [X_WIDTH:0]        abs_dx;
  logic [Y_WIDTH:0]        abs_dy;
  logic                    outlier;
  logic                    take;

  logic signed [SW-1:0]    sum_dx, sum_dy;
  logic [SW-1:0]           mag_dx, mag_dy;
  logic [CNT_WIDTH-1:0]    acc_count, rej_acc;
  logic [CNT_WIDTH-1:0]    cnt_l, rej_l;
  logic                    neg_dx, neg_dy;

  logic [X_WIDTH:0]        q_dx;
  logic [Y_WIDTH:0]        q_dy;
  logic                    done_x, done_y, div_done;

  assign dx      = $signed({1'b0, current_feature_X}) - $signed({1'b0, prev_feature_X});
  assign dy      = $signed({1'b0, current_feature_Y}) - $signed({1'b0, prev_feature_Y});
  assign abs_dx  = dx[X_WIDTH] ? -dx : dx;
  assign abs_dy  = dy[Y_WIDTH] ? -dy : dy;
  assign outlier = (abs_dx > MAX_DX) || (abs_dy > MAX_DY);
  assign take    = (state == ACCUM) && pair_valid && (acc_count != CNT_MAX);
  assign mag_dx  = sum_dx[SW-1] ? -sum_dx : sum_dx;
  assign mag_dy  = sum_dy[SW-1] ? -sum_dy : sum_dy;
  assign busy    = (state != ACCUM);
  assign div_done = done_x & done_y;

  seq_divider_u #(.W(SW), .DW(CNT_WIDTH), .QW(X_WIDTH + 1)) u_div_dx (
    .clk(clk), .rst(reset), .start(state == LOAD),
    .dividend(mag_dx), .divisor(acc_count), .quotient(q_dx), .done(done_x)
  );

  seq_divider_u #(.W(SW), .DW(CNT_WIDTH), .QW(Y_WIDTH + 1)) u_div_dy (
    .clk(clk), .rst(reset), .start(state == LOAD),
    .dividend(mag_dy), .divisor(acc_count), .quotient(q_dy), .done(done_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      ACCUM:   if (pair_done) next = LOAD;
      LOAD:    next = DIV;
      DIV:     if (div_done) next = DONE;
      DONE:    next = ACCUM;
      default: next = ACCUM;
    endcase
  end

  // LOAD hands the sums to the dividers on the same edge that clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_dx    <= '0;
      sum_dy    <= '0;
      acc_count <= '0;
      rej_acc   <= '0;
      cnt_l     <= '0;
      rej_l     <= '0;
      neg_dx    <= 1'b0;
      neg_dy    <= 1'b0;
    end else if (state == LOAD) begin
      cnt_l     <= acc_count;
      rej_l     <= rej_acc;
      neg_dx    <= sum_dx[SW-1];
      neg_dy    <= sum_dy[SW-1];
      sum_dx    <= '0;
      sum_dy    <= '0;
      acc_count <= '0;
      rej_acc   <= '0;
    end else if (take) begin
      if (outlier) begin
        if (rej_acc != CNT_MAX) rej_acc <= rej_acc + 1'b1;
      end else begin
        sum_dx    <= sum_dx + {{EXT_X{dx[X_WIDTH]}}, dx};
        sum_dy    <= sum_dy + {{EXT_Y{dy[Y_WIDTH]}}, dy};
        acc_count <= acc_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motion_valid <= 1'b0;
      motion_dx    <= '0;
      motion_dy    <= '0;
      motion_empty <= 1'b0;
      pair_count   <= '0;
      reject_count <= '0;
    end else begin
      motion_valid <= 1'b0;
      if (state == DONE) begin
        motion_valid <= 1'b1;
        motion_empty <= (cnt_l == '0);
        pair_count   <= cnt_l;
        reject_count <= rej_l;
        motion_dx    <= (cnt_l == '0) ? '0 : (neg_dx ? -q_dx : q_dx);
        motion_dy    <= (cnt_l == '0) ? '0 : (neg_dy ? -q_dy : q_dy);
      end
    end
  end

endmodule

// File: tb/tb_pair_motion_estimator.sv
// Scoreboard bench for pair_motion_estimator: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever motion_valid is seen.
module tb_pair_motion_estimator;

  localparam int LAT = 23;

  typedef struct {
    int dx;
    int dy;
    int empty;
    int pc;
    int rc;
    int vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pair_valid = 1'b0;
  logic pair_done = 1'b0;
  logic [9:0] current_feature_X = '0;
  logic [9:0] current_feature_Y = '0;
  logic [9:0] prev_feature_X = '0;
  logic [9:0] prev_feature_Y = '0;
  logic busy;
  logic motion_valid;
  logic signed [10:0] motion_dx;
  logic signed [10:0] motion_dy;
  logic motion_empty;
  logic [9:0] pair_count;
  logic [9:0] reject_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t sb[$];
  exp_t m;

  pair_motion_estimator #(.X_WIDTH(10), .Y_WIDTH(10), .CNT_WIDTH(10), .MAX_DISP(31)) dut (
    .clk(clk), .reset(reset), .pair_valid(pair_valid), .pair_done(pair_done),
    .current_feature_X(current_feature_X), .current_feature_Y(current_feature_Y),
    .prev_feature_X(prev_feature_X), .prev_feature_Y(prev_feature_Y),
    .busy(busy), .motion_valid(motion_valid), .motion_dx(motion_dx), .motion_dy(motion_dy),
    .motion_empty(motion_empty), .pair_count(pair_count), .reject_count(reject_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (motion_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_motion_valid", 1, 0);
      end else begin
        m = sb.pop_front();
        chk("motion_dx", int'(motion_dx), m.dx);
        chk("motion_dy", int'(motion_dy), m.dy);
        chk("motion_empty", int'(motion_empty), m.empty);
        chk("pair_count", int'(pair_count), m.pc);
        chk("reject_count", int'(reject_count), m.rc);
        chk("latency_cycle", cyc, m.vcyc);
        chk("busy_low_with_valid", int'(busy), 0);
      end
    end
  end

  task automatic pair(input int cx, input int cy, input int px, input int py, input bit with_done);
    current_feature_X = 10'(cx);
    current_feature_Y = 10'(cy);
    prev_feature_X    = 10'(px);
    prev_feature_Y    = 10'(py);
    pair_valid = 1'b1;
    pair_done  = with_done;
    @(posedge clk);
    #1;
    pair_valid = 1'b0;
    pair_done  = 1'b0;
  endtask

  task automatic expect_frame(input int dx, input int dy, input int empty, input int pc, input int rc);
    exp_t e;
    e.dx = dx; e.dy = dy; e.empty = empty; e.pc = pc; e.rc = rc;
    e.vcyc = cyc + 1 + LAT;
    sb.push_back(e);
  endtask

  task automatic done_pulse();
    pair_done = 1'b1;
    @(posedge clk);
    #1;
    pair_done = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("result_timeout", sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_motion_valid", int'(motion_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_motion_dx", int'(motion_dx), 0);
    chk("reset_pair_count", int'(pair_count), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: three pairs of (+3,+2)
    pair(100, 50, 97, 48, 0);
    pair(10, 10, 7, 8, 0);
    pair(200, 100, 197, 98, 0);
    expect_frame(3, 2, 0, 3, 0);
    done_pulse();
    chk("busy_after_done", int'(busy), 1);
    drain();

    // 2: dx -2, -3 -> -2 (truncate toward zero)
    pair(10, 5, 12, 5, 0);
    pair(10, 5, 13, 5, 0);
    expect_frame(-2, 0, 0, 2, 0);
    done_pulse();
    drain();

    // 3: one outlier between two +4 pairs
    pair(20, 20, 16, 20, 0);
    pair(150, 20, 110, 20, 0);
    pair(30, 30, 26, 30, 0);
    expect_frame(4, 0, 0, 2, 1);
    done_pulse();
    drain();

    // 4: empty frame
    expect_frame(0, 0, 1, 0, 0);
    done_pulse();
    drain();

    // 5: last pair coincident with pair_done; traffic while busy is dropped
    pair(50, 60, 45, 57, 0);
    expect_frame(6, 4, 0, 2, 0);
    pair(60, 60, 53, 55, 1);
    pair(40, 40, 20, 20, 0);
    pair(41, 40, 21, 20, 1);
    repeat (5) pair(30, 30, 10, 10, 0);
    drain();
    pair(5, 1, 4, 4, 0);
    expect_frame(1, -3, 0, 1, 0);
    done_pulse();
    drain();

    // 6: reset ten cycles into the division
    pair(10, 10, 8, 7, 0);
    done_pulse();
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_motion_valid", int'(motion_valid), 0);
    chk("abort_motion_dx", int'(motion_dx), 0);
    chk("abort_motion_dy", int'(motion_dy), 0);
    chk("abort_pair_count", int'(pair_count), 0);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    pair(100, 100, 90, 95, 0);
    pair(100, 100, 100, 100, 0);
    expect_frame(5, 2, 0, 2, 0);
    done_pulse();
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
